// File: rtl/fetch_pipe_pkg.sv
// Shared types and constants for the instruction fetch pipeline.
package fetch_pipe_pkg;

  localparam int unsigned BP_PHT_BITS = 8;
  localparam int unsigned MAX_N       = 8;
  localparam int unsigned OFF_W       = 3;

  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  typedef struct packed {
    logic [31:0]            pc;
    logic [31:0]            inst;
    logic                   is_branch;
    logic                   bp_pred_taken;
    logic [31:0]            bp_pred_target;
    logic [BP_PHT_BITS-1:0] bp_ghr_snapshot;
  } fetch_entry_t;

  // live must stay the MSB: the metadata FIFO kill clears the top bit.
  typedef struct packed {
    logic             live;
    logic [OFF_W-1:0] offset;
  } fetch_meta_t;

  // Sized for the widest bundle; lanes at and above N are unused.
  typedef struct packed {
    logic [31:0]                 pc;
    logic [MAX_N-1:0][31:0]      insts;
    logic [MAX_N-1:0]            mask;
  } fq_entry_t;

  function automatic logic is_ctrl_op(input logic [31:0] inst);
    return (inst[6:0] == OPC_BRANCH) || (inst[6:0] == OPC_JAL);
  endfunction

  function automatic logic [31:0] j_imm(input logic [31:0] inst);
    return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; kill clears the MSB of every stored entry.
module fetch_fifo #(
  parameter int unsigned W     = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic [W-1:0]             push_data,
  input  logic                     pop,
  input  logic                     flush,
  input  logic                     kill,
  output logic [W-1:0]             head,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty   = (count == '0);
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & ((count != CNT_W'(DEPTH)) | pop_ok);
  assign head    = mem[rd_ptr];

  // Pointers and occupancy; flush discards everything including a same-cycle push.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  always_ff @(posedge clock) begin
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (kill) mem[i][W-1] <= 1'b0;
    end
    if (push_ok && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_pipe.sv
// Fetch pipeline: icache request generation, response queueing and
// per-bundle control-flow prediction feeding the instruction buffer.
module fetch_pipe
  import fetch_pipe_pkg::*;
#(
  parameter int unsigned N        = 2,
  parameter int unsigned Q_DEPTH  = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_enable_i,
  output logic                   ic_req_valid_o,
  input  logic                   ic_req_ready_i,
  output logic [31:0]            ic_req_addr_o,
  input  logic                   ic_resp_valid_i,
  input  logic [N*32-1:0]        ic_resp_data_i,
  output logic                   bp_req_valid_o,
  output logic [31:0]            bp_req_pc_o,
  input  logic                   bp_resp_taken_i,
  input  logic [31:0]            bp_resp_target_i,
  input  logic [BP_PHT_BITS-1:0] bp_resp_ghr_i,
  output logic                   ib_valid_o,
  input  logic                   ib_ready_i,
  output fetch_entry_t [N-1:0]   ib_fetch_o,
  output logic [N-1:0]           ib_lane_mask_o,
  input  logic                   redirect_valid_i,
  input  logic [31:0]            redirect_pc_i,
  output logic [31:0]            pc_dbg_o
);

  localparam int unsigned CNT_W      = $clog2(Q_DEPTH) + 1;
  localparam int unsigned BLK_BYTES  = N * 4;
  localparam logic [31:0] ALIGN_MASK = ~(32'(BLK_BYTES) - 32'd1);
  localparam int unsigned META_W     = $bits(fetch_meta_t);
  localparam int unsigned FQ_W       = $bits(fq_entry_t);

  logic [31:0]      req_pc;
  logic [31:0]      resp_pc;
  logic [31:0]      req_base;
  logic             req_fire;
  logic             ib_fire;
  logic             taken_fire;
  logic             kill_all;

  fetch_meta_t      meta_push_data;
  fetch_meta_t      meta_head;
  logic [CNT_W-1:0] meta_count;
  logic             meta_empty;
  logic             meta_pop;

  fq_entry_t        fq_push_data;
  fq_entry_t        fq_head;
  logic [CNT_W-1:0] fq_count;
  logic             fq_empty;
  logic             fq_push;

  logic             ctrl_found;
  logic             ctrl_jal;
  logic [OFF_W-1:0] ctrl_idx;
  logic [31:0]      ctrl_inst;
  logic [31:0]      ctrl_pc;
  logic             pred_taken;
  logic [31:0]      pred_target;
  logic             unused_fq;

  assign req_base   = req_pc & ALIGN_MASK;
  assign kill_all   = redirect_valid_i | taken_fire;
  assign req_fire   = ic_req_valid_o & ic_req_ready_i;
  assign ib_fire    = ib_valid_o & ib_ready_i;
  assign taken_fire = ib_fire & pred_taken;

  // Credits cover both in-flight blocks and queued bundles so the queue cannot overflow.
  assign ic_req_valid_o = ~reset & fetch_enable_i & ~redirect_valid_i &
                          ((meta_count + fq_count) < CNT_W'(Q_DEPTH));
  assign ic_req_addr_o  = req_base;
  assign pc_dbg_o       = req_pc;

  assign meta_push_data.live   = ~kill_all;
  assign meta_push_data.offset = OFF_W'((req_pc >> 2) & 32'(N - 1));
  assign meta_pop              = ic_resp_valid_i & ~meta_empty;
  assign fq_push               = meta_pop & meta_head.live;

  fetch_fifo #(.W(META_W), .DEPTH(Q_DEPTH)) u_meta_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (req_fire),
    .push_data (meta_push_data),
    .pop       (meta_pop),
    .flush     (1'b0),
    .kill      (kill_all),
    .head      (meta_head),
    .count     (meta_count),
    .empty     (meta_empty)
  );

  // Response lanes below the request offset were not asked for.
  always_comb begin
    fq_push_data    = '0;
    fq_push_data.pc = resp_pc;
    for (int i = 0; i < int'(N); i++) begin
      fq_push_data.insts[i] = ic_resp_data_i[i*32 +: 32];
      fq_push_data.mask[i]  = (OFF_W'(i) >= meta_head.offset);
    end
  end

  fetch_fifo #(.W(FQ_W), .DEPTH(Q_DEPTH)) u_fetch_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (fq_push),
    .push_data (fq_push_data),
    .pop       (ib_fire),
    .flush     (kill_all),
    .kill      (1'b0),
    .head      (fq_head),
    .count     (fq_count),
    .empty     (fq_empty)
  );

  assign unused_fq = ^fq_head;

  // First valid branch/JAL lane of the head bundle.
  always_comb begin
    ctrl_found = 1'b0;
    ctrl_jal   = 1'b0;
    ctrl_idx   = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (!ctrl_found && fq_head.mask[i] && is_ctrl_op(fq_head.insts[i])) begin
        ctrl_found = 1'b1;
        ctrl_idx   = OFF_W'(i);
        ctrl_jal   = (fq_head.insts[i][6:0] == OPC_JAL);
      end
    end
  end

  assign ctrl_inst      = fq_head.insts[ctrl_idx];
  assign ctrl_pc        = fq_head.pc + (32'(ctrl_idx) << 2);
  assign bp_req_valid_o = ~fq_empty & ctrl_found & ~ctrl_jal;
  assign bp_req_pc_o    = ctrl_pc;
  assign pred_taken     = ~fq_empty & ctrl_found & (ctrl_jal | bp_resp_taken_i);
  assign pred_target    = ctrl_jal ? (ctrl_pc + j_imm(ctrl_inst)) : bp_resp_target_i;
  assign ib_valid_o     = ~fq_empty & ~redirect_valid_i;

  always_comb begin
    ib_fetch_o     = '0;
    ib_lane_mask_o = '0;
    for (int i = 0; i < int'(N); i++) begin
      ib_fetch_o[i].pc        = fq_head.pc + 32'(i * 4);
      ib_fetch_o[i].inst      = fq_head.insts[i];
      ib_fetch_o[i].is_branch = fq_head.mask[i] & is_ctrl_op(fq_head.insts[i]);
      if (ctrl_found && (OFF_W'(i) == ctrl_idx)) begin
        ib_fetch_o[i].bp_pred_taken   = pred_taken;
        ib_fetch_o[i].bp_pred_target  = pred_target;
        ib_fetch_o[i].bp_ghr_snapshot = bp_resp_ghr_i;
      end
      ib_lane_mask_o[i] = ib_valid_o & fq_head.mask[i] &
                          ~(pred_taken & (OFF_W'(i) > ctrl_idx));
    end
  end

  // req_pc steers new requests; resp_pc tracks the block of the next live response.
  always_ff @(posedge clock) begin
    if (reset) begin
      req_pc  <= RESET_PC;
      resp_pc <= RESET_PC & ALIGN_MASK;
    end else if (redirect_valid_i) begin
      req_pc  <= redirect_pc_i;
      resp_pc <= redirect_pc_i & ALIGN_MASK;
    end else if (taken_fire) begin
      req_pc  <= pred_target;
      resp_pc <= pred_target & ALIGN_MASK;
    end else begin
      if (req_fire) req_pc  <= req_base + 32'(BLK_BYTES);
      if (fq_push)  resp_pc <= resp_pc + 32'(BLK_BYTES);
    end
  end

  resp_has_meta: assert property (@(posedge clock) disable iff (reset)
    ic_resp_valid_i |-> !meta_empty);

endmodule

// File: tb/tb_fetch_pipe.sv
// Directed self-checking bench for fetch_pipe (N=2, Q_DEPTH=4, RESET_PC=0).
module tb_fetch_pipe;
  import fetch_pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] JAL40 = 32'h0400_006F;
  localparam logic [31:0] BEQ = 32'h0000_0063;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic fetch_enable_i = 1'b0;
  logic ic_req_valid_o;
  logic ic_req_ready_i = 1'b1;
  logic [31:0] ic_req_addr_o;
  logic ic_resp_valid_i = 1'b0;
  logic [63:0] ic_resp_data_i = '0;
  logic bp_req_valid_o;
  logic [31:0] bp_req_pc_o;
  logic bp_resp_taken_i = 1'b0;
  logic [31:0] bp_resp_target_i = '0;
  logic [BP_PHT_BITS-1:0] bp_resp_ghr_i = '0;
  logic ib_valid_o;
  logic ib_ready_i = 1'b0;
  fetch_entry_t [1:0] ib_fetch_o;
  logic [1:0] ib_lane_mask_o;
  logic redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_dbg_o;

  fetch_pipe #(.N(2), .Q_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clock(clock), .reset(reset), .fetch_enable_i(fetch_enable_i),
    .ic_req_valid_o(ic_req_valid_o), .ic_req_ready_i(ic_req_ready_i),
    .ic_req_addr_o(ic_req_addr_o), .ic_resp_valid_i(ic_resp_valid_i),
    .ic_resp_data_i(ic_resp_data_i), .bp_req_valid_o(bp_req_valid_o),
    .bp_req_pc_o(bp_req_pc_o), .bp_resp_taken_i(bp_resp_taken_i),
    .bp_resp_target_i(bp_resp_target_i), .bp_resp_ghr_i(bp_resp_ghr_i),
    .ib_valid_o(ib_valid_o), .ib_ready_i(ib_ready_i), .ib_fetch_o(ib_fetch_o),
    .ib_lane_mask_o(ib_lane_mask_o), .redirect_valid_i(redirect_valid_i),
    .redirect_pc_i(redirect_pc_i), .pc_dbg_o(pc_dbg_o)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  logic resp_hold = 1'b0;
  logic [31:0] imem [logic [31:0]];
  logic [31:0] pend [$];
  logic [31:0] req_log [$];
  logic [31:0] bnd_pc [$];
  logic [1:0]  bnd_mask [$];

  typedef struct {
    logic [31:0] pc;
    logic        bp_taken;
    logic [31:0] bp_target;
    logic [1:0]  mask;
    logic        bpv;
    logic [31:0] bppc;
    logic [1:0]  isbr;
    logic [1:0]  taken;
    int          ctrl;
    logic [31:0] target;
  } vec_t;
  vec_t vecs [7];

  function automatic logic [31:0] imem_rd(input logic [31:0] a);
    return imem.exists(a) ? imem[a] : NOP;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: log handshakes before the edge, then update the icache model.
  task automatic step();
    logic fire;
    logic [31:0] a;
    #3;
    fire = ic_req_valid_o && ic_req_ready_i;
    a = ic_req_addr_o;
    if (fire) req_log.push_back(a);
    if (ib_valid_o && ib_ready_i) begin
      bnd_pc.push_back(ib_lane_mask_o[0] ? ib_fetch_o[0].pc : ib_fetch_o[1].pc);
      bnd_mask.push_back(ib_lane_mask_o);
    end
    @(posedge clock);
    #1;
    ic_resp_valid_i = 1'b0;
    if (reset) begin
      pend.delete();
    end else begin
      if (fire) pend.push_back(a);
      if (!resp_hold && pend.size() > 0) begin
        ic_resp_valid_i = 1'b1;
        ic_resp_data_i = {imem_rd(pend[0] + 32'd4), imem_rd(pend[0])};
        void'(pend.pop_front());
      end
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    req_log.delete();
    bnd_pc.delete();
    bnd_mask.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int n;
    int waited;
    imem[32'h20]  = JAL40;
    imem[32'h44]  = BEQ;
    imem[32'h80]  = BEQ;
    imem[32'h84]  = BEQ;
    imem[32'hC0]  = JAL40;
    imem[32'h300] = BEQ;
    //          pc         bpT   bpTgt        mask   bpv   bppc         isbr   taken ctrl target
    vecs[0] = '{32'h0,     1'b0, 32'h0,       2'b11, 1'b0, 32'h0,       2'b00, 2'b00, 0, 32'h0};
    vecs[1] = '{32'h104,   1'b0, 32'h0,       2'b10, 1'b0, 32'h0,       2'b00, 2'b00, 0, 32'h0};
    vecs[2] = '{32'h20,    1'b0, 32'h0,       2'b01, 1'b0, 32'h0,       2'b01, 2'b01, 0, 32'h60};
    vecs[3] = '{32'h40,    1'b1, 32'h200,     2'b11, 1'b1, 32'h44,      2'b10, 2'b10, 1, 32'h200};
    vecs[4] = '{32'h80,    1'b0, 32'h0,       2'b11, 1'b1, 32'h80,      2'b11, 2'b00, 0, 32'h0};
    vecs[5] = '{32'hC4,    1'b0, 32'h0,       2'b10, 1'b0, 32'h0,       2'b00, 2'b00, 0, 32'h0};
    vecs[6] = '{32'h300,   1'b1, 32'h1000,    2'b01, 1'b1, 32'h300,     2'b01, 2'b01, 0, 32'h1000};

    // Reset state with fetch enabled.
    fetch_enable_i = 1'b1;
    reset = 1'b1;
    step();
    step();
    settle();
    check("rst_pc", pc_dbg_o, 32'h0);
    check("rst_req_valid", 32'(ic_req_valid_o), 32'h0);
    check("rst_ib_valid", 32'(ib_valid_o), 32'h0);
    check("rst_lane_mask", 32'(ib_lane_mask_o), 32'h0);
    check("rst_bp_valid", 32'(bp_req_valid_o), 32'h0);

    // Streaming NOPs from reset.
    reset = 1'b0;
    req_log.delete();
    ib_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("seq_req_cnt_ge3", 32'(req_log.size() >= 3), 32'h1);
    check("seq_bnd_cnt_ge3", 32'(bnd_pc.size() >= 3), 32'h1);
    for (int i = 0; i < 3; i++) begin
      if (i < req_log.size()) check("seq_req_addr", req_log[i], 32'(i * 8));
      if (i < bnd_pc.size()) begin
        check("seq_bnd_pc", bnd_pc[i], 32'(i * 8));
        check("seq_bnd_mask", 32'(bnd_mask[i]), 32'h3);
      end
    end

    // Redirect with two requests outstanding.
    ib_ready_i = 1'b0;
    do_reset();
    resp_hold = 1'b1;
    step();
    step();
    req_log.delete();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h104;
    settle();
    check("rd_no_req", 32'(ic_req_valid_o), 32'h0);
    step();
    redirect_valid_i = 1'b0;
    resp_hold = 1'b0;
    ib_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("rd_bnd_cnt_ge2", 32'(bnd_pc.size() >= 2), 32'h1);
    if (req_log.size() > 0) check("rd_first_req", req_log[0], 32'h100);
    if (bnd_pc.size() >= 2) begin
      check("rd_first_pc", bnd_pc[0], 32'h104);
      check("rd_first_mask", 32'(bnd_mask[0]), 32'h2);
      check("rd_second_pc", bnd_pc[1], 32'h108);
    end

    // Backpressure: credit limit of Q_DEPTH.
    ib_ready_i = 1'b0;
    do_reset();
    for (int i = 0; i < 10; i++) step();
    settle();
    check("bp_req_cnt", 32'(req_log.size()), 32'd4);
    check("bp_req_blocked", 32'(ic_req_valid_o), 32'h0);
    ib_ready_i = 1'b1;
    step();
    ib_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check("bp_req_after_pop", 32'(req_log.size()), 32'd5);

    // Redirect and ib_ready in the same cycle.
    n = bnd_pc.size();
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h500;
    ib_ready_i = 1'b1;
    settle();
    check("rr_ib_valid", 32'(ib_valid_o), 32'h0);
    check("rr_no_req", 32'(ic_req_valid_o), 32'h0);
    step();
    redirect_valid_i = 1'b0;
    ib_ready_i = 1'b0;
    settle();
    check("rr_no_consume", 32'(bnd_pc.size()), 32'(n));
    check("rr_queue_empty", 32'(ib_valid_o), 32'h0);
    check("rr_pc", pc_dbg_o, 32'h500);

    // Table-driven bundle prediction vectors.
    bp_resp_ghr_i = 8'hA5;
    for (int v = 0; v < 7; v++) begin
      ib_ready_i = 1'b0;
      bp_resp_taken_i = vecs[v].bp_taken;
      bp_resp_target_i = vecs[v].bp_target;
      redirect_valid_i = 1'b1;
      redirect_pc_i = vecs[v].pc;
      step();
      redirect_valid_i = 1'b0;
      settle();
      waited = 0;
      while (!ib_valid_o && waited < 20) begin
        step();
        settle();
        waited++;
      end
      check($sformatf("v%0d_valid", v), 32'(ib_valid_o), 32'h1);
      check($sformatf("v%0d_mask", v), 32'(ib_lane_mask_o), 32'(vecs[v].mask));
      check($sformatf("v%0d_lane0_pc", v), ib_fetch_o[0].pc, vecs[v].pc & 32'hFFFF_FFF8);
      check($sformatf("v%0d_lane1_pc", v), ib_fetch_o[1].pc, (vecs[v].pc & 32'hFFFF_FFF8) + 32'd4);
      check($sformatf("v%0d_bp_valid", v), 32'(bp_req_valid_o), 32'(vecs[v].bpv));
      if (vecs[v].bpv) check($sformatf("v%0d_bp_pc", v), bp_req_pc_o, vecs[v].bppc);
      check($sformatf("v%0d_is_branch", v),
            32'({ib_fetch_o[1].is_branch, ib_fetch_o[0].is_branch}), 32'(vecs[v].isbr));
      check($sformatf("v%0d_taken", v),
            32'({ib_fetch_o[1].bp_pred_taken, ib_fetch_o[0].bp_pred_taken}), 32'(vecs[v].taken));
      if (vecs[v].taken != 2'b00) begin
        check($sformatf("v%0d_target", v), ib_fetch_o[vecs[v].ctrl].bp_pred_target, vecs[v].target);
        check($sformatf("v%0d_ghr", v), 32'(ib_fetch_o[vecs[v].ctrl].bp_ghr_snapshot), 32'hA5);
      end
      ib_ready_i = 1'b1;
      step();
      ib_ready_i = 1'b0;
      settle();
      if (vecs[v].taken != 2'b00) begin
        check($sformatf("v%0d_next_pc", v), pc_dbg_o, vecs[v].target);
        check($sformatf("v%0d_next_addr", v), ic_req_addr_o, vecs[v].target & 32'hFFFF_FFF8);
        check($sformatf("v%0d_flushed", v), 32'(ib_valid_o), 32'h0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pipe.md
FETCH_PIPE -- requirements
Module: fetch_pipe

Interface
REQ-001 Parameter: N, 2, instructions per fetch bundle (power of 2, 1..8).
REQ-002 Parameter: Q_DEPTH, 4, fetch-queue entries and maximum outstanding blocks (power of 2, >=2).
REQ-003 Parameter: RESET_PC, 32'h0, PC loaded on reset.
REQ-004 Clocking SHALL be: reset reset, synchronous, active-high; clock clock.
REQ-005 Ports SHALL be:
- clock  input  1  system clock.
- reset  input  1  synchronous active-high reset.
- fetch_enable_i  input  1  permits new icache requests.
- ic_req_valid_o  output  1  icache request this cycle.
- ic_req_ready_i  input  1  icache accepts request.
- ic_req_addr_o  output  32  block address aligned to N*4.
- ic_resp_valid_i  input  1  in-order response; always accepted.
- ic_resp_data_i  input  N*32  block instructions, lane i at addr+4i.
- bp_req_valid_o  output  1  prediction query.
- bp_req_pc_o  output  32  PC of queried branch.
- bp_resp_taken_i  input  1  same-cycle prediction.
- bp_resp_target_i  input  32  predicted target.
- bp_resp_ghr_i  input  BP_PHT_BITS  GHR snapshot.
- ib_valid_o  output  1  bundle valid to instruction buffer.
- ib_ready_i  input  1  instruction buffer accepts.
- ib_fetch_o  output  N x FETCH_ENTRY  bundle lanes.
- ib_lane_mask_o  output  N  valid lanes of bundle.
- redirect_valid_i  input  1  EX/ROB redirect.
- redirect_pc_i  input  32  redirect target.
- pc_dbg_o  output  32  next request PC.

Function
REQ-006 Request SHALL be asserted when fetch_enable_i, no redirect this cycle, and inflight+queue_count < Q_DEPTH; valid is per-cycle and need not persist.
REQ-007 On request fire (valid&ready), req_pc SHALL become align(req_pc)+4N; lane offset req_pc[$clog2(N)+1:2] and live=1 SHALL be pushed to the in-flight metadata FIFO.
REQ-008 On ic_resp_valid_i, head metadata SHALL pop; live entries write the fetch queue with mask = lanes >= offset; dead entries are discarded.
REQ-009 Response with empty metadata FIFO SHALL be ignored and flagged by assertion; the credit rule in REQ-006 guarantees the queue never overflows.
REQ-010 At queue head, first masked lane with opcode 1100011 (branch) or 1101111 (JAL) SHALL be the control lane; bp_req_valid_o=1 only for a branch, bp_req_pc_o its PC.
REQ-011 JAL SHALL be predicted taken with target pc + sign-extended J-immediate; branch uses bp_resp_*.
REQ-012 If control lane predicted taken, lanes above it SHALL be masked off; control lane carries is_branch=1, bp_pred_taken, bp_pred_target, bp_ghr_snapshot; later branches flagged is_branch with taken=0.
REQ-013 ib_valid_o SHALL equal queue non-empty and no redirect; on ib_valid_o&ib_ready_i the head pops; if predicted taken, same edge: queue flushed, all in-flight entries marked dead, req_pc <= target.
REQ-014 redirect_valid_i SHALL have priority over everything: ib_valid_o=0, no request issued, queue flushed, all in-flight entries dead, req_pc <= redirect_pc_i.
REQ-015 Queue push and pop in the same cycle SHALL both take effect; flush overrides a same-cycle push.
REQ-016 fetch_enable_i low SHALL stop requests only; responses and bundle delivery continue.
REQ-017 pc_dbg_o SHALL equal req_pc.

Reset
REQ-018 On reset: req_pc=RESET_PC, queue and metadata FIFO empty; ic_req_valid_o, bp_req_valid_o, ib_valid_o, ib_lane_mask_o all 0.
REQ-019 Reset mid-operation SHALL abandon outstanding requests; icache is reset in the same cycle.

Structure
REQ-020 FETCH_ENTRY, opcode constants, FETCH_META_T {live, offset} and FQ_ENTRY_T {pc, insts, mask} SHALL live in the shared package.
REQ-021 One sub-module fetch_fifo (parameterised width/depth, push, pop, flush, count) SHALL implement both queues; metadata FIFO adds a kill-all input.

Verification (N=2, Q_DEPTH=4, RESET_PC=0)
REQ-022 Reset, ready=1, 1-cycle responses of NOPs -> requests 0x0,0x8,0x10; bundles in order, mask 2'b11.
REQ-023 Redirect to 0x104 with two requests outstanding -> next request 0x100, two stale responses dropped, first bundle pc 0x104 mask 2'b10.
REQ-024 Bundle 0x20, lane0 JAL +0x40 -> mask 2'b01, pred_taken=1 target 0x60, next request 0x60.
REQ-025 Bundle 0x40, lane1 branch, BP taken target 0x200 -> mask 2'b11, lane1 is_branch=1, next request 0x200.
REQ-026 ib_ready_i=0 for 10 cycles -> exactly 4 requests issued, then none until a pop.
REQ-027 redirect_valid_i and ib_ready_i same cycle -> ib_valid_o=0, no bundle consumed, queue empty next cycle.
